ref_window_loader: RTL and testbench
====================================

Name: ref_window_loader

Overview:
- Upstream feeder for subpixel_interpolation.
- Accepts a raster stream of 8-bit reference-frame pixels with valid/ready and assembles a 15x15 integer-pixel window: an 8x8 block plus the 3-left/top and 4-right/bottom filter margin.
- Presents the window as the flat 1800-bit in_buffer vector.
- Double-buffered, so one window can fill while the previous one is held for the interpolator.

Parameters:
- PIX_W, 8, bits per pixel.
- WIN, 15, window edge in pixels. Window vector width is WIN*WIN*PIX_W = 1800.
- CNT_W, 8, width of the saturating abort counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  loader can accept a pixel.
- in_sop  in  1  marks the first pixel (row 0, col 0) of a window.
- in_pixel  in  PIX_W  pixel value, raster order: row-major, col 0..14 within each row.
- win_valid  out  1  a complete window is presented.
- win_ready  in  1  consumer accepts the window.
- win_data  out  WIN*WIN*PIX_W  window vector. Pixel (row r, col c) sits at bits [8*c + 120*r +: 8].
- abort_cnt  out  CNT_W  saturating count of partial windows discarded.

Behaviour:
- Reset (async, any time including mid-fill):
  - Both banks and all counters clear; partial fill is dropped.
  - FSM goes to WAIT_SOP; abort_cnt = 0.
  - win_valid = 0; win_data = 0; in_ready = 1 on the first cycle after reset deasserts.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when win_valid & win_ready.
  - in_ready = (full_cnt < 2). It is a pure function of registered state, with no combinational path from in_valid.
  - win_valid = (full_cnt > 0). win_data = bank[rd_ptr]; it is stable while win_valid is high and win_ready is low.
- Storage:
  - Two banks of 1800 bits each, plus wr_ptr, rd_ptr and full_cnt (0..2).
  - The fill bank is always bank[wr_ptr], which is guaranteed free whenever in_ready = 1.
- FSM:
  - WAIT_SOP, accepted pixel with in_sop = 0: pixel is dropped and the state is held.
  - WAIT_SOP, accepted pixel with in_sop = 1: write it to (0,0); col = 1, row = 0; go to FILL.
  - FILL, accepted pixel with in_sop = 0: write to (row, col); increment col; on col = 14 wrap col to 0 and increment row.
  - FILL, accepted pixel at (14,14):
    - Write the pixel, set full_cnt += 1 and toggle wr_ptr; go to WAIT_SOP.
    - win_valid rises on the next cycle, so latency is 1 cycle from the last pixel.
  - FILL, accepted pixel with in_sop = 1 (restart):
    - The partial window is discarded and abort_cnt increments, saturating at 2^CNT_W-1.
    - The pixel is written to (0,0) of the same bank; col = 1, row = 0; stay in FILL.
- Bank bookkeeping:
  - On output transfer: full_cnt -= 1 and rd_ptr toggles.
  - Fill completion and output transfer in the same cycle: full_cnt is unchanged, both pointers toggle.
  - full_cnt = 2: in_ready = 0 and input stalls with no pixel loss. A fill may not start, because in_ready covers the WAIT_SOP state too.
- Stale data: bank contents are not cleared on release. Stale data is permitted only while win_valid = 0.
- Arithmetic: col and row are 4-bit counters. Pixel data passes through unmodified (no rounding or clipping).

Decomposition:
- Shared package (subpel_pkg), used by this block and subpixel_interpolation:
  - PIX_W, WIN, WIN_BITS = 1800.
  - Helper function pix_idx(r,c) = 8*c + 120*r.
  - Loader state enum {WAIT_SOP, FILL}.
- One natural sub-module: win_bank_pair. It owns the two banks, wr_ptr/rd_ptr/full_cnt, the write strobe with (r,c) address, and the release strobe.
- The FSM and counters stay in the top module.

Test Plan:
- Single window: stream 225 pixels with value (15r+c) mod 256, sop on the first, win_ready = 1.
  - win_valid rises 1 cycle after the 225th transfer.
  - win_data[7:0] = 0x00, win_data[127:120] = 0x0F, win_data[1799:1792] = 0xE0.
  - win_valid drops the following cycle.
- Backpressure: win_ready = 0, stream 3 windows back-to-back.
  - in_ready falls 1 cycle after the 450th transfer.
  - Window 1 data holds steady.
  - Raising win_ready for 1 cycle presents window 2 and reasserts in_ready.
  - Window 3 completes intact.
- Restart: sop at pixel 0, then sop again at pixel 100, then 224 further pixels.
  - abort_cnt = 1; exactly one window is emitted, containing only the second sequence.
- Leading garbage: 10 valid pixels without sop, then a proper window.
  - All 10 are dropped (in_ready = 1 throughout); the emitted window equals the proper window.
  - abort_cnt stays 0.
- Reset mid-fill: assert reset after 150 pixels, with one full window also pending.
  - win_valid = 0, win_data = 0, abort_cnt = 0 immediately.
  - A subsequent full window is emitted correctly from bank 0.
- Simultaneous: one window pending, win_ready = 1 held while the next fill completes.
  - full_cnt stays 1; win_valid remains high continuously; window 2 follows window 1 with no gap.

Source files
------------

// File: rtl/subpel_pkg.sv
// rtl/subpel_pkg.sv - shared constants, window indexing helper and loader state type
package subpel_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN      = 15;
  localparam int WIN_BITS = WIN * WIN * PIX_W;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    FILL     = 1'b1
  } loader_state_e;

  // Bit offset of pixel (r, c) inside the flat window vector: 8*c + 120*r.
  function automatic logic [10:0] pix_idx(input logic [3:0] r, input logic [3:0] c);
    return (11'(c) * 11'd8) + (11'(r) * 11'd120);
  endfunction

endpackage

// File: rtl/win_bank_pair.sv
// rtl/win_bank_pair.sv - two window banks with fill/read pointers and occupancy count
module win_bank_pair
  import subpel_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [3:0]          i_wr_row,
  input  logic [3:0]          i_wr_col,
  input  logic [PIX_W-1:0]    i_wr_pix,
  input  logic                i_wr_last,
  input  logic                i_release,
  output logic                o_in_ready,
  output logic                o_win_valid,
  output logic [WIN_BITS-1:0] o_win_data
);

  logic [WIN_BITS-1:0] r_bank0;
  logic [WIN_BITS-1:0] r_bank1;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_full_cnt;
  logic [10:0]         w_idx;
  logic                w_commit;

  assign w_idx    = pix_idx(i_wr_row, i_wr_col);
  assign w_commit = i_wr_en & i_wr_last;

  // Pixel writes always land in the bank selected by the fill pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bank0 <= '0;
      r_bank1 <= '0;
    end else if (i_wr_en) begin
      if (r_wr_ptr) r_bank1[w_idx +: PIX_W] <= i_wr_pix;
      else          r_bank0[w_idx +: PIX_W] <= i_wr_pix;
    end
  end

  // Pointer and occupancy bookkeeping; a commit and a release in the same cycle cancel in the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_full_cnt <= 2'd0;
    end else begin
      if (w_commit)  r_wr_ptr <= ~r_wr_ptr;
      if (i_release) r_rd_ptr <= ~r_rd_ptr;
      case ({w_commit, i_release})
        2'b10:   r_full_cnt <= r_full_cnt + 2'd1;
        2'b01:   r_full_cnt <= r_full_cnt - 2'd1;
        default: r_full_cnt <= r_full_cnt;
      endcase
    end
  end

  assign o_in_ready  = (r_full_cnt < 2'd2);
  assign o_win_valid = (r_full_cnt != 2'd0);
  assign o_win_data  = r_rd_ptr ? r_bank1 : r_bank0;

endmodule

// File: rtl/ref_window_loader.sv
// rtl/ref_window_loader.sv - raster pixel stream to double-buffered 15x15 reference window
module ref_window_loader
  import subpel_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic                i_in_sop,
  input  logic [PIX_W-1:0]    i_in_pixel,
  output logic                o_win_valid,
  input  logic                i_win_ready,
  output logic [WIN_BITS-1:0] o_win_data,
  output logic [CNT_W-1:0]    o_abort_cnt
);

  loader_state_e    r_state;
  logic [3:0]       r_row;
  logic [3:0]       r_col;
  logic [CNT_W-1:0] r_abort_cnt;

  logic             w_accept;
  logic             w_wr_en;
  logic             w_last;
  logic             w_release;
  logic [3:0]       w_wr_row;
  logic [3:0]       w_wr_col;

  // An sop pixel always restarts at (0,0); otherwise only FILL stores pixels.
  assign w_accept  = i_in_valid & o_in_ready;
  assign w_wr_en   = w_accept & ((r_state == FILL) | i_in_sop);
  assign w_wr_row  = i_in_sop ? 4'd0 : r_row;
  assign w_wr_col  = i_in_sop ? 4'd0 : r_col;
  assign w_last    = (r_state == FILL) & ~i_in_sop & (r_row == 4'd14) & (r_col == 4'd14);
  assign w_release = o_win_valid & i_win_ready;

  win_bank_pair u_banks (
    .i_clk       (i_clk),
    .i_rst       (i_reset),
    .i_wr_en     (w_wr_en),
    .i_wr_row    (w_wr_row),
    .i_wr_col    (w_wr_col),
    .i_wr_pix    (i_in_pixel),
    .i_wr_last   (w_last),
    .i_release   (w_release),
    .o_in_ready  (o_in_ready),
    .o_win_valid (o_win_valid),
    .o_win_data  (o_win_data)
  );

  // Fill sequencer: tracks the raster position and counts restarted (discarded) windows.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= WAIT_SOP;
      r_row       <= 4'd0;
      r_col       <= 4'd0;
      r_abort_cnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        WAIT_SOP: begin
          if (i_in_sop) begin
            r_row   <= 4'd0;
            r_col   <= 4'd1;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (i_in_sop) begin
            if (r_abort_cnt != '1) r_abort_cnt <= r_abort_cnt + CNT_W'(1);
            r_row <= 4'd0;
            r_col <= 4'd1;
          end else if (w_last) begin
            r_row   <= 4'd0;
            r_col   <= 4'd0;
            r_state <= WAIT_SOP;
          end else if (r_col == 4'd14) begin
            r_col <= 4'd0;
            r_row <= r_row + 4'd1;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        default: r_state <= WAIT_SOP;
      endcase
    end
  end

  assign o_abort_cnt = r_abort_cnt;

endmodule

// File: tb/tb_ref_window_loader.sv
// tb/tb_ref_window_loader.sv - randomized bench with a queue-based window model
module tb_ref_window_loader;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_sop;
  logic [7:0]   in_pixel;
  logic         win_valid;
  logic         win_ready;
  logic [1799:0] win_data;
  logic [7:0]   abort_cnt;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 0;

  // model state
  logic [7:0]    m_part[$];
  logic [1799:0] m_q[$];
  bit            m_fill;
  int            m_abort;
  int            m_acc;
  int            n_out;

  logic [7:0] wbuf[225];

  ref_window_loader #(.CNT_W(8)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_sop    (in_sop),
    .i_in_pixel  (in_pixel),
    .o_win_valid (win_valid),
    .i_win_ready (win_ready),
    .o_win_data  (win_data),
    .o_abort_cnt (abort_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_data(input string nm, input logic [1799:0] got, input logic [1799:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      for (int k = 0; k < 225; k++) begin
        if (got[8*k +: 8] !== exp[8*k +: 8]) begin
          $display("FAIL %s: pixel r%0d c%0d got %h expected %h at %0t",
                   nm, k / 15, k % 15, got[8*k +: 8], exp[8*k +: 8], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [1799:0] pack_part();
    logic [1799:0] v = '0;
    for (int k = 0; k < 225; k++) v[8*k +: 8] = m_part[k];
    return v;
  endfunction

  // Behavioural model: a window is the 225 pixels after the latest sop; completed windows queue up (max 2).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_part.delete();
      m_fill  = 0;
      m_abort = 0;
    end else begin
      bit took, rel;
      took = in_valid && (m_q.size() < 2);
      rel  = (m_q.size() > 0) && win_ready;
      if (rel) void'(m_q.pop_front());
      if (took) begin
        m_acc++;
        if (in_sop) begin
          if (m_fill && m_abort < 255) m_abort++;
          m_part.delete();
          m_part.push_back(in_pixel);
          m_fill = 1;
        end else if (m_fill) begin
          m_part.push_back(in_pixel);
          if (m_part.size() == 225) begin
            m_q.push_back(pack_part());
            m_fill = 0;
          end
        end
      end
    end
  end

  always @(posedge clk) if (!reset && win_valid && win_ready) n_out++;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
      chk("win_valid", 32'(win_valid), 32'(m_q.size() > 0));
      chk("abort_cnt", 32'(abort_cnt), 32'(m_abort));
      if (m_q.size() > 0) chk_data("win_data", win_data, m_q[0]);
    end
  end

  task automatic send(input logic [7:0] p, input bit s);
    int c0 = m_acc;
    int t = 0;
    in_valid = 1; in_sop = s; in_pixel = p;
    while (m_acc == c0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    if (m_acc == c0) chk("send_timeout", 32'(t), 32'(0));
    in_valid = 0; in_sop = 0;
  endtask

  task automatic send_wbuf(input int n);
    for (int k = 0; k < n; k++) send(wbuf[k], k == 0);
  endtask

  task automatic rand_wbuf();
    for (int k = 0; k < 225; k++) wbuf[k] = 8'($urandom);
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (m_acc < target && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    if (m_acc < target) chk("wait_acc_timeout", 32'(m_acc), 32'(target));
  endtask

  task automatic wait_empty();
    int t = 0;
    while (m_q.size() > 0 && t < 3000) begin
      @(posedge clk); #1; t++;
    end
    chk("drain", 32'(m_q.size()), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, o0;
    reset = 1; in_valid = 0; in_sop = 0; in_pixel = 0; win_ready = 0;
    m_fill = 0; m_abort = 0; m_acc = 0; n_out = 0;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    chk_on = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_win_valid", 32'(win_valid), 32'd0);
    chk("rst_win_data_zero", 32'(win_data != '0), 32'd0);
    chk("rst_abort", 32'(abort_cnt), 32'd0);
    @(posedge clk); #1;

    // single window with value 15r+c
    win_ready = 1;
    for (int k = 0; k < 225; k++) wbuf[k] = 8'(k);
    send_wbuf(225);
    @(negedge clk);
    chk("single_valid", 32'(win_valid), 32'd1);
    chk("single_px00", 32'(win_data[7:0]), 32'h00);
    chk("single_px10", 32'(win_data[127:120]), 32'h0F);
    chk("single_px1414", 32'(win_data[1799:1792]), 32'hE0);
    @(negedge clk);
    chk("single_drop", 32'(win_valid), 32'd0);
    @(posedge clk); #1;

    // backpressure: three windows, consumer stalled
    win_ready = 0;
    base = m_acc;
    fork
      begin
        for (int w = 0; w < 3; w++) begin
          rand_wbuf();
          send_wbuf(225);
        end
      end
      begin
        wait_acc(base + 450);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (20) @(negedge clk);
        chk("bp_still_stalled", 32'(m_acc), 32'(base + 450));
        @(posedge clk); #1 win_ready = 1;
        @(posedge clk); #1 win_ready = 0;
        @(negedge clk);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);
      end
    join
    @(negedge clk);
    chk("bp_two_pending", 32'(in_ready), 32'd0);
    @(posedge clk); #1 win_ready = 1;
    wait_empty();

    // restart mid-window
    chk("restart_abort_before", 32'(abort_cnt), 32'd0);
    o0 = n_out;
    rand_wbuf();
    send_wbuf(100);
    rand_wbuf();
    send_wbuf(225);
    wait_empty();
    @(negedge clk);
    chk("restart_abort_after", 32'(abort_cnt), 32'd1);
    chk("restart_one_window", 32'(n_out - o0), 32'd1);
    @(posedge clk); #1;

    // leading garbage without sop
    o0 = n_out;
    for (int k = 0; k < 10; k++) send(8'($urandom), 0);
    rand_wbuf();
    send_wbuf(225);
    wait_empty();
    @(negedge clk);
    chk("garbage_abort", 32'(abort_cnt), 32'd1);
    chk("garbage_one_window", 32'(n_out - o0), 32'd1);
    @(posedge clk); #1;

    // reset mid-fill with one window pending
    win_ready = 0;
    rand_wbuf();
    send_wbuf(225);
    rand_wbuf();
    send_wbuf(150);
    #2 reset = 1;
    #1;
    chk("midrst_valid", 32'(win_valid), 32'd0);
    chk("midrst_data_zero", 32'(win_data != '0), 32'd0);
    chk("midrst_abort", 32'(abort_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(posedge clk); #1;
    win_ready = 1;
    rand_wbuf();
    send_wbuf(225);
    wait_empty();

    // simultaneous fill completion and output transfer
    win_ready = 0;
    rand_wbuf();
    send_wbuf(225);
    rand_wbuf();
    for (int k = 0; k < 224; k++) send(wbuf[k], k == 0);
    win_ready = 1;
    o0 = n_out;
    send(wbuf[224], 0);
    @(negedge clk);
    chk("simul_valid_held", 32'(win_valid), 32'd1);
    chk("simul_in_ready", 32'(in_ready), 32'd1);
    chk("simul_first_out", 32'(n_out - o0), 32'd1);
    wait_empty();

    // randomized traffic
    begin
      bit rnd_on;
      rnd_on = 1;
      fork
        begin
          for (int w = 0; w < 12; w++) begin
            int g;
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) send(8'($urandom), 0);
            if ($urandom_range(0, 3) == 0) begin
              rand_wbuf();
              send_wbuf($urandom_range(1, 224));
            end
            rand_wbuf();
            for (int k = 0; k < 225; k++) begin
              if ($urandom_range(0, 5) == 0) begin
                @(posedge clk); #1;
              end
              send(wbuf[k], k == 0);
            end
          end
          rnd_on = 0;
        end
        begin
          while (rnd_on) begin
            @(posedge clk); #1;
            win_ready = ($urandom_range(0, 2) != 0);
          end
        end
      join
    end
    win_ready = 1;
    wait_empty();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
